audio_dac_frame_sequencer: RTL and testbench
============================================

Name: audio_dac_frame_sequencer

Overview:
- Sequences I2S playback frames for the audio DAC path.
- Pulls one stereo sample pair per LRCK frame from the upstream sample FIFO using a valid/ready handshake.
- Serializes the pair MSB-first onto the DAC data line, using the single-cycle bit-clock and LRCK edge strobes from the clock-edge detector.
- Tracks underflow when the FIFO has nothing ready at frame start.

Parameters:
- DATA_WIDTH, 16, bits per channel sample (legal range 8..32; must not exceed the LRCK half-period in bit clocks).
- UFLOW_CNT_WIDTH, 8, width of the saturating underflow counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  playback enable (level).
- clear_underflow  input  1  one-cycle pulse; zeroes underflow_count.
- bit_clk_falling_edge  input  1  one-cycle strobe.
- left_right_clk_rising_edge  input  1  one-cycle strobe; starts the right channel.
- left_right_clk_falling_edge  input  1  one-cycle strobe; starts the left channel and the frame.
- sample_valid  input  1  FIFO has a stereo pair.
- sample_left  input  DATA_WIDTH  left sample.
- sample_right  input  DATA_WIDTH  right sample.
- sample_ready  output  1  pop strobe to the FIFO.
- serial_data  output  1  DAC serial data line.
- busy  output  1  high in LEFT or RIGHT state.
- underflow_count  output  UFLOW_CNT_WIDTH  saturating count of starved frames.

Behaviour:
- Reset (async): state=IDLE; serial_data=0, sample_ready=0, busy=0, underflow_count=0; shift register and bit counter =0.
- FSM states: IDLE, SYNC, LEFT, RIGHT.
  - IDLE: enable=1 → SYNC.
  - SYNC: LRCK falling edge → LEFT (frame start).
  - LEFT: LRCK rising edge → RIGHT.
  - RIGHT: LRCK falling edge → LEFT if enable=1, else IDLE.
- enable dropping in SYNC → IDLE immediately. enable dropping in LEFT or RIGHT finishes the current frame and never aborts mid-sample.
- Frame start (LRCK falling edge in SYNC, or in RIGHT with enable=1):
  - sample_valid=1: assert sample_ready for exactly that cycle; latch sample_left and sample_right in the same cycle.
  - sample_valid=0: sample_ready stays 0; load zeros; underflow_count +1, saturating at all-ones.
- sample_ready is never asserted outside a frame-start cycle.
- Channel load:
  - Every LRCK edge accepted in LEFT or RIGHT loads that channel's word into the shifter and sets bits_remaining=DATA_WIDTH.
  - bits_remaining width is clog2(DATA_WIDTH+1).
- Shifting (I2S one-bit delay):
  - serial_data changes only on bit_clk_falling_edge.
  - While bits_remaining>0, each falling edge drives the next bit MSB-first and decrements bits_remaining.
  - When bits_remaining=0, each falling edge drives 0.
  - The MSB is therefore driven on the first falling edge after the LRCK edge.
- Simultaneous LRCK edge and bit_clk_falling_edge: the LRCK load wins and no bit is shifted that cycle.
- Both LRCK strobes in one cycle: the falling edge wins.
- An LRCK edge that arrives before bits_remaining=0 truncates the rest of the word; the new channel reloads.
- busy=1 in LEFT or RIGHT. In IDLE/SYNC, serial_data is held at 0 on the next bit_clk_falling_edge.
- clear_underflow takes priority over a same-cycle increment; the result is 0.

Optional Feature:
- Macro AUDIO_DAC_UNDERFLOW_REPEAT_EN.
- Defined: on underflow, the last successfully played pair is replayed instead of zeros, and the counter still increments.
- Undefined: zeros are played.
- The last-pair registers are reset to 0.

Decomposition:
- Package audio_dac_pkg: state enum (IDLE, SYNC, LEFT, RIGHT) and the default DATA_WIDTH constant.
- Sub-module audio_channel_shifter: shift register, bits_remaining counter and serial_data register.
  - Inputs: load, load_data, shift strobe.
  - The FSM, handshake and underflow logic stay in the top module.

Test Plan:
- Normal frame: enable=1, FIFO holds 16'hA5C3 and 16'h0F01, LRCK falling edge → sample_ready pulses once. Falling edges 1..16 then drive 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, followed by zeros. After the LRCK rising edge, the right channel drives 0000111100000001.
- Underflow: sample_valid=0 at 3 consecutive frame starts → underflow_count=3, serial_data all 0, sample_ready never asserted. With AUDIO_DAC_UNDERFLOW_REPEAT_EN defined, the previous pair 16'hA5C3/16'h0F01 repeats.
- Saturation/clear: UFLOW_CNT_WIDTH=2, 5 starved frames → count=3. clear_underflow coincident with a 6th underflow → count=0.
- Collision: bit_clk_falling_edge in the same cycle as the LRCK falling edge → no bit shifted that cycle; the MSB appears on the next falling edge.
- Enable drop in LEFT: the frame completes through RIGHT, then the FSM goes to IDLE at the next LRCK falling edge with no sample_ready.
- Async reset asserted mid-RIGHT, between clk edges → serial_data, busy, underflow_count read 0 immediately. After release, no sample_ready until the next LRCK falling edge after enable.

Source files
------------

// File: rtl/audio_dac_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// audio_dac_pkg
// Shared types and default constants for the audio DAC frame sequencer.
//   seq_state_e             : frame sequencer FSM states
//   DEFAULT_DATA_WIDTH      : default bits per channel sample
//   DEFAULT_UFLOW_CNT_WIDTH : default width of the underflow counter
// ---------------------------------------------------------------------------
package audio_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } seq_state_e;

    localparam int DEFAULT_DATA_WIDTH      = 16;
    localparam int DEFAULT_UFLOW_CNT_WIDTH = 8;

endpackage

// File: rtl/audio_dac_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// audio_dac_frame_sequencer_if
// Valid/ready sample-pair channel between the upstream sample FIFO and the
// frame sequencer.
//   sample_valid : FIFO holds a stereo pair              (FIFO -> sequencer)
//   sample_left  : left channel sample                   (FIFO -> sequencer)
//   sample_right : right channel sample                  (FIFO -> sequencer)
//   sample_ready : one-cycle pop strobe                  (sequencer -> FIFO)
// Modports: master = FIFO side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface audio_dac_frame_sequencer_if
    import audio_dac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;
    logic                  sample_ready;

    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

// File: rtl/audio_dac_frame_sequencer_shifter.sv
// ---------------------------------------------------------------------------
// audio_channel_shifter
// MSB-first serializer for one channel word.
//   clk, reset  : system clock, asynchronous active-high reset
//   load        : load load_data and arm DATA_WIDTH bits (wins over shift)
//   load_data   : channel word to serialize
//   shift       : bit-clock falling-edge strobe; drives the next bit, or 0
//                 once the word is exhausted
//   serial_data : registered DAC data line
// ---------------------------------------------------------------------------
module audio_channel_shifter
    import audio_dac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    output logic                  serial_data
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bits_remaining_q, bits_remaining_d;
    logic                  serial_data_q, serial_data_d;

    // Next-state: a load only arms the word; the line moves on shift strobes.
    always_comb begin
        shreg_d          = shreg_q;
        bits_remaining_d = bits_remaining_q;
        serial_data_d    = serial_data_q;
        if (load) begin
            shreg_d          = load_data;
            bits_remaining_d = CNT_W'(DATA_WIDTH);
        end else if (shift) begin
            if (bits_remaining_q != {CNT_W{1'b0}}) begin
                serial_data_d    = shreg_q[DATA_WIDTH-1];
                shreg_d          = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                bits_remaining_d = bits_remaining_q - CNT_W'(1);
            end else begin
                serial_data_d    = 1'b0;
            end
        end else begin
            serial_data_d    = serial_data_q;
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q          <= {DATA_WIDTH{1'b0}};
            bits_remaining_q <= {CNT_W{1'b0}};
            serial_data_q    <= 1'b0;
        end else begin
            shreg_q          <= shreg_d;
            bits_remaining_q <= bits_remaining_d;
            serial_data_q    <= serial_data_d;
        end
    end

    assign serial_data = serial_data_q;
endmodule

// File: rtl/audio_dac_frame_sequencer.sv
// ---------------------------------------------------------------------------
// audio_dac_frame_sequencer
// Pulls one stereo pair per LRCK frame from the sample FIFO and serializes it
// I2S-style (one bit-clock delay, MSB first) onto the DAC data line.
//   clk, reset                  : system clock, async active-high reset
//   enable                      : playback enable (level)
//   clear_underflow             : pulse, zeroes underflow_count
//   bit_clk_falling_edge        : bit-clock falling-edge strobe
//   left_right_clk_rising_edge  : starts the right channel
//   left_right_clk_falling_edge : starts the left channel and the frame
//   fifo                        : valid/ready sample-pair interface (slave)
//   serial_data                 : DAC serial data line
//   busy                        : high in LEFT or RIGHT
//   underflow_count             : saturating count of starved frames
// Optional build macro AUDIO_DAC_UNDERFLOW_REPEAT_EN: a starved frame
// replays the last successfully fetched pair instead of playing zeros.
// ---------------------------------------------------------------------------
module audio_dac_frame_sequencer
    import audio_dac_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int UFLOW_CNT_WIDTH = DEFAULT_UFLOW_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear_underflow,
    input  logic                       bit_clk_falling_edge,
    input  logic                       left_right_clk_rising_edge,
    input  logic                       left_right_clk_falling_edge,
    audio_dac_frame_sequencer_if.slave fifo,
    output logic                       serial_data,
    output logic                       busy,
    output logic [UFLOW_CNT_WIDTH-1:0] underflow_count
);
    seq_state_e                 state_q, state_d;
    logic                       busy_q, busy_d;
    logic [UFLOW_CNT_WIDTH-1:0] uflow_q, uflow_d;
    logic [DATA_WIDTH-1:0]      right_word_q, right_word_d;

    logic                  lrck_fall_s;
    logic                  lrck_rise_s;
    logic                  frame_start_s;
    logic                  sample_ready_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [DATA_WIDTH-1:0] fill_left_s;
    logic [DATA_WIDTH-1:0] fill_right_s;

    // A falling LRCK strobe masks a coincident rising one.
    assign lrck_fall_s = left_right_clk_falling_edge;
    assign lrck_rise_s = left_right_clk_rising_edge & ~left_right_clk_falling_edge;

`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
    logic [DATA_WIDTH-1:0] last_left_q, last_left_d;
    logic [DATA_WIDTH-1:0] last_right_q, last_right_d;

    // Remember the most recently fetched pair for replay on a starved frame.
    always_comb begin
        if (sample_ready_s) begin
            last_left_d  = fifo.sample_left;
            last_right_d = fifo.sample_right;
        end else begin
            last_left_d  = last_left_q;
            last_right_d = last_right_q;
        end
    end

    // Last-pair registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_left_q  <= {DATA_WIDTH{1'b0}};
            last_right_q <= {DATA_WIDTH{1'b0}};
        end else begin
            last_left_q  <= last_left_d;
            last_right_q <= last_right_d;
        end
    end

    assign fill_left_s  = last_left_q;
    assign fill_right_s = last_right_q;
`else
    assign fill_left_s  = {DATA_WIDTH{1'b0}};
    assign fill_right_s = {DATA_WIDTH{1'b0}};
`endif

    // FSM next state, frame-start handshake, channel loads and underflow.
    always_comb begin
        state_d       = state_q;
        frame_start_s = 1'b0;
        load_s        = 1'b0;
        load_data_s   = {DATA_WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SYNC;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (lrck_fall_s) begin
                    state_d       = LEFT;
                    frame_start_s = 1'b1;
                    load_s        = 1'b1;
                end else begin
                    state_d = SYNC;
                end
            end
            LEFT: begin
                if (lrck_rise_s) begin
                    state_d     = RIGHT;
                    load_s      = 1'b1;
                    load_data_s = right_word_q;
                end else begin
                    state_d = LEFT;
                end
            end
            RIGHT: begin
                if (lrck_fall_s) begin
                    // Leaving for IDLE loads zeros so the line idles low.
                    load_s = 1'b1;
                    if (enable) begin
                        state_d       = LEFT;
                        frame_start_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RIGHT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sample_ready_s = frame_start_s & fifo.sample_valid;
        right_word_d   = right_word_q;
        if (frame_start_s) begin
            if (fifo.sample_valid) begin
                load_data_s  = fifo.sample_left;
                right_word_d = fifo.sample_right;
            end else begin
                load_data_s  = fill_left_s;
                right_word_d = fill_right_s;
            end
        end else begin
            right_word_d = right_word_q;
        end

        // Clear beats a same-cycle increment; increments saturate.
        if (clear_underflow) begin
            uflow_d = {UFLOW_CNT_WIDTH{1'b0}};
        end else if (frame_start_s && !fifo.sample_valid &&
                     (uflow_q != {UFLOW_CNT_WIDTH{1'b1}})) begin
            uflow_d = uflow_q + UFLOW_CNT_WIDTH'(1);
        end else begin
            uflow_d = uflow_q;
        end

        busy_d = (state_d == LEFT) || (state_d == RIGHT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            uflow_q      <= {UFLOW_CNT_WIDTH{1'b0}};
            right_word_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            uflow_q      <= uflow_d;
            right_word_q <= right_word_d;
        end
    end

    audio_channel_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .load_data   (load_data_s),
        .shift       (bit_clk_falling_edge),
        .serial_data (serial_data)
    );

    // The pop strobe must coincide with the latch cycle, so it is decoded
    // directly from the frame-start condition.
    assign fifo.sample_ready = sample_ready_s;
    assign busy              = busy_q;
    assign underflow_count   = uflow_q;
endmodule

// File: tb/tb_audio_dac_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_dac_frame_sequencer
// Directed bench for audio_dac_frame_sequencer (DATA_WIDTH=16,
// UFLOW_CNT_WIDTH=2). Honours AUDIO_DAC_UNDERFLOW_REPEAT_EN for the expected
// starved-frame data.
// ---------------------------------------------------------------------------
module tb_audio_dac_frame_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_underflow;
    logic       bit_clk_falling_edge;
    logic       left_right_clk_rising_edge;
    logic       left_right_clk_falling_edge;
    logic       serial_data;
    logic       busy;
    logic [1:0] underflow_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    audio_dac_frame_sequencer_if #(.DATA_WIDTH(16)) fifo_if ();

    audio_dac_frame_sequencer #(
        .DATA_WIDTH      (16),
        .UFLOW_CNT_WIDTH (2)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .enable                      (enable),
        .clear_underflow             (clear_underflow),
        .bit_clk_falling_edge        (bit_clk_falling_edge),
        .left_right_clk_rising_edge  (left_right_clk_rising_edge),
        .left_right_clk_falling_edge (left_right_clk_falling_edge),
        .fifo                        (fifo_if.slave),
        .serial_data                 (serial_data),
        .busy                        (busy),
        .underflow_count             (underflow_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; ready is sampled mid-cycle.
    task automatic tick(input logic bf, input logic lr, input logic lf,
                        output logic rdy);
        bit_clk_falling_edge        = bf;
        left_right_clk_rising_edge  = lr;
        left_right_clk_falling_edge = lf;
        #1;
        rdy = fifo_if.sample_ready;
        @(posedge clk);
        #1;
        bit_clk_falling_edge        = 1'b0;
        left_right_clk_rising_edge  = 1'b0;
        left_right_clk_falling_edge = 1'b0;
    endtask

    // n bit-clock falling edges, collecting serial_data MSB-first.
    task automatic collect(input int n, output logic [31:0] w);
        logic r;
        w = 32'h0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 1'b0, r);
            w = {w[30:0], serial_data};
        end
    endtask

    initial begin
        logic        rdy;
        logic [31:0] w;
        logic [31:0] exp_l;
        logic [31:0] exp_r;

`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
        exp_l = 32'h0000_A5C3;
        exp_r = 32'h0000_0F01;
`else
        exp_l = 32'h0000_0000;
        exp_r = 32'h0000_0000;
`endif
        reset                       = 1'b1;
        enable                      = 1'b0;
        clear_underflow             = 1'b0;
        bit_clk_falling_edge        = 1'b0;
        left_right_clk_rising_edge  = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        fifo_if.sample_valid        = 1'b0;
        fifo_if.sample_left         = 16'h0000;
        fifo_if.sample_right        = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_sd",    {31'd0, serial_data}, 32'd0);
        check_value("rst_busy",  {31'd0, busy}, 32'd0);
        check_value("rst_cnt",   {30'd0, underflow_count}, 32'd0);
        check_value("rst_ready", {31'd0, fifo_if.sample_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Normal frame.
        enable               = 1'b1;
        fifo_if.sample_valid = 1'b1;
        fifo_if.sample_left  = 16'hA5C3;
        fifo_if.sample_right = 16'h0F01;
        tick(1'b0, 1'b0, 1'b0, rdy);
        check_value("sync_ready", {31'd0, rdy}, 32'd0);
        check_value("sync_busy", {31'd0, busy}, 32'd0);
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("frame_ready", {31'd0, rdy}, 32'd1);
        check_value("frame_busy", {31'd0, busy}, 32'd1);
        check_value("frame_sd0", {31'd0, serial_data}, 32'd0);
        fifo_if.sample_valid = 1'b0;
        collect(16, w);
        check_value("left_bits", w, 32'h0000_A5C3);
        collect(2, w);
        check_value("left_tail", w, 32'h0);
        tick(1'b0, 1'b1, 1'b0, rdy);
        check_value("rise_ready", {31'd0, rdy}, 32'd0);
        collect(16, w);
        check_value("right_bits", w, 32'h0000_0F01);

        // Three starved frames.
        for (int f = 0; f < 3; f++) begin
            tick(1'b0, 1'b0, 1'b1, rdy);
            check_value("uflow_ready", {31'd0, rdy}, 32'd0);
            collect(16, w);
            check_value("uflow_left", w, exp_l);
            tick(1'b0, 1'b1, 1'b0, rdy);
            collect(16, w);
            check_value("uflow_right", w, exp_r);
        end
        check_value("uflow_cnt3", {30'd0, underflow_count}, 32'd3);

        // Saturation, then clear coincident with a sixth underflow.
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("sat_cnt4", {30'd0, underflow_count}, 32'd3);
        tick(1'b0, 1'b1, 1'b0, rdy);
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("sat_cnt5", {30'd0, underflow_count}, 32'd3);
        tick(1'b0, 1'b1, 1'b0, rdy);
        clear_underflow = 1'b1;
        tick(1'b0, 1'b0, 1'b1, rdy);
        clear_underflow = 1'b0;
        check_value("clear_cnt", {30'd0, underflow_count}, 32'd0);
        collect(17, w);
        check_value("clear_sd_tail", {31'd0, serial_data}, 32'd0);
        tick(1'b0, 1'b1, 1'b0, rdy);

        // Collision of bit-clock and LRCK falling edges, then truncation.
        fifo_if.sample_valid = 1'b1;
        fifo_if.sample_left  = 16'h8001;
        fifo_if.sample_right = 16'h4002;
        tick(1'b1, 1'b0, 1'b1, rdy);
        check_value("coll_ready", {31'd0, rdy}, 32'd1);
        check_value("coll_noshift", {31'd0, serial_data}, 32'd0);
        fifo_if.sample_valid = 1'b0;
        tick(1'b1, 1'b0, 1'b0, rdy);
        check_value("coll_msb", {31'd0, serial_data}, 32'd1);
        collect(3, w);
        check_value("trunc_left", w, 32'h0);
        tick(1'b0, 1'b1, 1'b0, rdy);
        collect(16, w);
        check_value("trunc_right", w, 32'h0000_4002);
        check_value("coll_cnt", {30'd0, underflow_count}, 32'd0);

        // Both LRCK strobes at once: falling edge wins.
        fifo_if.sample_valid = 1'b1;
        fifo_if.sample_left  = 16'h7FFE;
        fifo_if.sample_right = 16'h1235;
        tick(1'b0, 1'b1, 1'b1, rdy);
        check_value("both_ready", {31'd0, rdy}, 32'd1);
        fifo_if.sample_valid = 1'b0;
        collect(16, w);
        check_value("both_left", w, 32'h0000_7FFE);

        // Enable drop in LEFT: frame completes, then IDLE without a pop.
        enable = 1'b0;
        tick(1'b0, 1'b1, 1'b0, rdy);
        check_value("drop_busy_r", {31'd0, busy}, 32'd1);
        collect(16, w);
        check_value("drop_right", w, 32'h0000_1235);
        fifo_if.sample_valid = 1'b1;
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("drop_ready", {31'd0, rdy}, 32'd0);
        check_value("drop_busy", {31'd0, busy}, 32'd0);
        tick(1'b1, 1'b0, 1'b0, rdy);
        check_value("idle_sd", {31'd0, serial_data}, 32'd0);
        fifo_if.sample_valid = 1'b0;

        // Async reset mid-RIGHT.
        enable = 1'b1;
        tick(1'b0, 1'b0, 1'b0, rdy);
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("rst_pre_cnt", {30'd0, underflow_count}, 32'd1);
        tick(1'b0, 1'b1, 1'b0, rdy);
        fifo_if.sample_valid = 1'b1;
        fifo_if.sample_left  = 16'hFFFF;
        fifo_if.sample_right = 16'hFFFF;
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("rst_pre_ready", {31'd0, rdy}, 32'd1);
        fifo_if.sample_valid = 1'b0;
        collect(2, w);
        check_value("rst_pre_bits", w, 32'h3);
        tick(1'b0, 1'b1, 1'b0, rdy);
        tick(1'b1, 1'b0, 1'b0, rdy);
        check_value("rst_pre_sd", {31'd0, serial_data}, 32'd1);
        check_value("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_value("arst_sd",   {31'd0, serial_data}, 32'd0);
        check_value("arst_busy", {31'd0, busy}, 32'd0);
        check_value("arst_cnt",  {30'd0, underflow_count}, 32'd0);
        #2;
        reset = 1'b0;
        fifo_if.sample_valid = 1'b1;
        tick(1'b0, 1'b0, 1'b0, rdy);
        check_value("post_idle_ready", {31'd0, rdy}, 32'd0);
        tick(1'b0, 1'b1, 1'b0, rdy);
        check_value("post_rise_ready", {31'd0, rdy}, 32'd0);
        tick(1'b0, 1'b0, 1'b1, rdy);
        check_value("post_fall_ready", {31'd0, rdy}, 32'd1);
        check_value("post_busy", {31'd0, busy}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end
endmodule
